// File: rtl/bsg_nand_checker.sv
// bsg_nand_checker: checks a NAND result stream, reports per-bit mismatch masks
// through a one-deep output stage and keeps pass/error counts plus the first failing beat.
module bsg_nand_checker #(
   parameter int width_p       = 16,
   parameter int count_width_p = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     v_i,
   output logic                     ready_o,
   input  logic [width_p-1:0]       a_i,
   input  logic [width_p-1:0]       b_i,
   input  logic [width_p-1:0]       o_i,
   input  logic                     clear_i,
   output logic                     v_o,
   input  logic                     ready_i,
   output logic [width_p-1:0]       mismatch_o,
   output logic                     err_o,
   output logic [count_width_p-1:0] pass_cnt_o,
   output logic [count_width_p-1:0] err_cnt_o,
   output logic [width_p-1:0]       first_a_o,
   output logic [width_p-1:0]       first_b_o,
   output logic [width_p-1:0]       first_o_o
);
   logic                     accept, bad;
   logic [width_p-1:0]       mask;
   logic [count_width_p-1:0] pass_base, err_base;
   logic                     err_base_f;
   assign ready_o = ~v_o | ready_i;
   assign accept  = v_i & ready_o;
   assign mask    = o_i ^ ~(a_i & b_i);
   assign bad     = |mask;
   // clear zeroes state first so a beat accepted in the same cycle still lands on top of it
   always_comb begin
      pass_base  = clear_i ? '0 : pass_cnt_o;
      err_base   = clear_i ? '0 : err_cnt_o;
      err_base_f = clear_i ? 1'b0 : err_o;
   end
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         v_o        <= 1'b0;
         mismatch_o <= '0;
         err_o      <= 1'b0;
         pass_cnt_o <= '0;
         err_cnt_o  <= '0;
         first_a_o  <= '0;
         first_b_o  <= '0;
         first_o_o  <= '0;
      end else begin
         v_o        <= accept | (v_o & ~ready_i);
         mismatch_o <= accept ? mask : mismatch_o;
         pass_cnt_o <= (accept & ~bad & ~&pass_base) ? pass_base + 1'b1 : pass_base;
         err_cnt_o  <= (accept & bad & ~&err_base) ? err_base + 1'b1 : err_base;
         err_o      <= err_base_f | (accept & bad);
         if (accept & bad & ~err_base_f) begin
            first_a_o <= a_i;
            first_b_o <= b_i;
            first_o_o <= o_i;
         end else if (clear_i) begin
            first_a_o <= '0;
            first_b_o <= '0;
            first_o_o <= '0;
         end
      end
endmodule
